// File: rtl/seg_scan_driver_if.sv
// ----------------------------------------------------------------------------
// seg_scan_driver_if
// Display-side bundle of the clock/calendar back-end.
//   data_show   [11]    upper-field enable
//               [10:6]  upper field (0..31)
//               [5:0]   lower field (0..63)
//   byte_status [2]     blank display
//               [1:0]   scan-rate select
//   segment     7-seg drive, active-high, [0]=a .. [6]=g
//   bytee       one-hot digit enable, bytee[3] = leftmost digit
// master: the producer of data_show/byte_status (selector side).
// slave : the display driver.
// ----------------------------------------------------------------------------
interface seg_scan_driver_if;
  logic [11:0] data_show;
  logic [2:0]  byte_status;
  logic [6:0]  segment;
  logic [3:0]  bytee;

  modport master (
    output data_show,
    output byte_status,
    input  segment,
    input  bytee
  );

  modport slave (
    input  data_show,
    input  byte_status,
    output segment,
    output bytee
  );
endinterface

// File: rtl/seg_scan_driver.sv
// ----------------------------------------------------------------------------
// seg_scan_driver
// 4-digit multiplexed 7-segment back-end. The two binary fields of data_show
// are converted to BCD by a sequential double-dabble engine (IDLE/CONV/COMMIT),
// committed atomically into four digit registers, and scanned out one digit
// at a time with a registered segment pattern and one-hot digit enable.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-low
//   disp   slave side of seg_scan_driver_if (data_show, byte_status in;
//          segment, bytee out)
// Parameter:
//   SCAN_BASE  log2 of the minimum dwell; dwell = 2^(SCAN_BASE+byte_status[1:0])
// ----------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int unsigned SCAN_BASE = 8
) (
  input  logic             clock,
  input  logic             reset,
  seg_scan_driver_if.slave disp
);

  localparam int unsigned CNT_W   = SCAN_BASE + 3;
  localparam int unsigned SHAMT_W = $clog2(CNT_W + 1);
  localparam int unsigned RAW_W   = 12;
  localparam int unsigned BIN_W   = 6;
  localparam int unsigned BCD_W   = 8;
  localparam int unsigned ITER_W  = 3;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NDIG    = 4;

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);
  localparam logic [DIG_W-1:0]  BLANK     = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Converter state
  state_e                       state_q,    state_d;
  logic [RAW_W-1:0]             last_raw_q, last_raw_d;
  logic [BIN_W-1:0]             up_bin_q,   up_bin_d;
  logic [BIN_W-1:0]             lo_bin_q,   lo_bin_d;
  logic [BCD_W-1:0]             up_bcd_q,   up_bcd_d;
  logic [BCD_W-1:0]             lo_bcd_q,   lo_bcd_d;
  logic [ITER_W-1:0]            iter_q,     iter_d;
  logic [NDIG-1:0][DIG_W-1:0]   digit_q,    digit_d;
  logic                         upper_en_q, upper_en_d;

  // Scanner and output stage
  logic [CNT_W-1:0]             cnt_q,      cnt_d;
  logic [1:0]                   idx_q,      idx_d;
  logic [SEG_W-1:0]             segment_q,  segment_d;
  logic [NDIG-1:0]              bytee_q,    bytee_d;

  logic [SHAMT_W-1:0]           shamt_c;
  logic [CNT_W-1:0]             tc_mask_c;
  logic                         tc_c;
  logic [DIG_W-1:0]             shown_c;

  // One double-dabble step: +3 on nibbles >= 5, then shift {bcd,bin} left.
  function automatic logic [BCD_W+BIN_W-1:0] dabble(
    input logic [BCD_W-1:0] bcd,
    input logic [BIN_W-1:0] bin
  );
    logic [BCD_W-1:0]       adj;
    logic [BCD_W+BIN_W-1:0] cat;
    adj = bcd;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    cat = {adj, bin};
    return cat << 1;
  endfunction

  // BCD digit to segment pattern; any non-decimal code blanks the digit.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [DIG_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Converter next-state and datapath
  always_comb begin
    state_d    = state_q;
    last_raw_d = last_raw_q;
    up_bin_d   = up_bin_q;
    lo_bin_d   = lo_bin_q;
    up_bcd_d   = up_bcd_q;
    lo_bcd_d   = lo_bcd_q;
    iter_d     = iter_q;
    digit_d    = digit_q;
    upper_en_d = upper_en_q;

    case (state_q)
      IDLE: begin
        // Input changes are only sampled here, so the display always
        // converges on the latest value without mixing two inputs.
        if (disp.data_show != last_raw_q) begin
          last_raw_d = disp.data_show;
          up_bin_d   = {1'b0, disp.data_show[10:6]};
          lo_bin_d   = disp.data_show[5:0];
          up_bcd_d   = '0;
          lo_bcd_d   = '0;
          iter_d     = '0;
          state_d    = CONV;
        end
      end
      CONV: begin
        {up_bcd_d, up_bin_d} = dabble(up_bcd_q, up_bin_q);
        {lo_bcd_d, lo_bin_d} = dabble(lo_bcd_q, lo_bin_q);
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == LAST_ITER) state_d = COMMIT;
      end
      COMMIT: begin
        digit_d    = {up_bcd_q[7:4], up_bcd_q[3:0], lo_bcd_q[7:4], lo_bcd_q[3:0]};
        upper_en_d = last_raw_q[11];
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Terminal count: low SCAN_BASE+sel counter bits all ones.
  assign shamt_c   = SHAMT_W'(SCAN_BASE) + SHAMT_W'(disp.byte_status[1:0]);
  assign tc_mask_c = ~({CNT_W{1'b1}} << shamt_c);
  assign tc_c      = ((cnt_q & tc_mask_c) == tc_mask_c);

  // Scanner and output stage next values
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    segment_d = '0;
    bytee_d   = '0;
    shown_c   = digit_q[idx_q];

    if (tc_c) idx_d = idx_q + 2'd1;
    // Upper digits (3,2) are blanked while the upper field is disabled.
    if (idx_q[1] && !upper_en_q) shown_c = BLANK;

    if (!disp.byte_status[2]) begin
      bytee_d   = NDIG'(1) << idx_q;
      segment_d = seg_decode(shown_c);
    end
  end

  // All state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_raw_q <= '0;
      up_bin_q   <= '0;
      lo_bin_q   <= '0;
      up_bcd_q   <= '0;
      lo_bcd_q   <= '0;
      iter_q     <= '0;
      digit_q    <= {NDIG{BLANK}};
      upper_en_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      segment_q  <= '0;
      bytee_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_raw_q <= last_raw_d;
      up_bin_q   <= up_bin_d;
      lo_bin_q   <= lo_bin_d;
      up_bcd_q   <= up_bcd_d;
      lo_bcd_q   <= lo_bcd_d;
      iter_q     <= iter_d;
      digit_q    <= digit_d;
      upper_en_q <= upper_en_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      segment_q  <= segment_d;
      bytee_q    <= bytee_d;
    end
  end

  assign disp.segment = segment_q;
  assign disp.bytee   = bytee_q;

endmodule
